// File: rtl/double_frame_buffer.sv
// Ping-pong RGB565 frame buffer: the writer fills one BRAM while the display reads
// the other upscaled by 2^SCALE_SHIFT. Optional stats counters: FB_FRAME_STATS_EN.
module double_frame_buffer #(
  parameter int SCREEN_WIDTH  = 320,
  parameter int SCREEN_HEIGHT = 180,
  parameter int SCALE_SHIFT   = 2,
  parameter int DEPTH         = SCREEN_WIDTH * SCREEN_HEIGHT,
  parameter int ADDR_WIDTH    = $clog2(DEPTH),
  parameter     INIT_FILE     = ""
) (
  input  logic                  pixel_clk_in,
  input  logic                  rst_in,
  input  logic [10:0]           hcount_in,
  input  logic [9:0]            vcount_in,
  input  logic                  frame_done_in,
  input  logic                  wr_valid_in,
  output logic                  wr_ready_out,
  input  logic [ADDR_WIDTH-1:0] wr_addr_in,
  input  logic [15:0]           wr_pixel_in,
  input  logic                  wr_last_in,
  output logic [23:0]           rgb_out,
  output logic                  rgb_valid_out,
  output logic                  swap_out,
  output logic                  write_buf_out,
  output logic                  addr_err_out
`ifdef FB_FRAME_STATS_EN
  ,
  output logic [15:0]           frames_shown_out,
  output logic [15:0]           frames_repeated_out
`endif
);

  // state       | meaning
  // ST_FILL     | writer filling, display still on its current frame
  // ST_WAIT_VID | writer finished, waiting for the display frame to end
  // ST_WAIT_WR  | display finished (repeats frames), waiting for the writer
  // ST_SWAP     | both finished; buffers exchange on the next edge
  typedef enum logic [1:0] {
    ST_FILL     = 2'd0,
    ST_WAIT_VID = 2'd1,
    ST_WAIT_WR  = 2'd2,
    ST_SWAP     = 2'd3
  } state_t;

  localparam int ACT_W = SCREEN_WIDTH << SCALE_SHIFT;
  localparam int ACT_H = SCREEN_HEIGHT << SCALE_SHIFT;

  state_t state_q, state_d;
  logic   write_buf_q, write_buf_d;
  logic   addr_err_q, addr_err_d;

  logic   wr_done, rd_done;
  logic   wr_fire, wr_in_range, wr_last_fire;

  logic [31:0]           h_ext, v_ext;
  logic                  rd_active;
  logic [ADDR_WIDTH-1:0] rd_addr;

  logic [15:0] mem0 [DEPTH];
  logic [15:0] mem1 [DEPTH];
  logic [15:0] mem0_rd_q, mem1_rd_q;

  logic        rd_sel1_q, rd_sel1_d;
  logic        act1_q, act1_d;
  logic [15:0] pix2_q, pix2_d;
  logic        act2_q, act2_d;
  logic [23:0] rgb_q, rgb_d;
  logic        valid_q, valid_d;

  function automatic logic [23:0] rgb565_to_888(input logic [15:0] p);
    return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
  endfunction

  // Done flags are encoded in the swap state rather than kept as separate flops.
  always_comb begin
    wr_done      = (state_q == ST_WAIT_VID) || (state_q == ST_SWAP);
    rd_done      = (state_q == ST_WAIT_WR)  || (state_q == ST_SWAP);
    wr_fire      = wr_valid_in && !wr_done;
    wr_in_range  = 32'(wr_addr_in) < 32'(DEPTH);
    wr_last_fire = wr_fire && wr_last_in;
  end

  always_comb begin
    state_d     = state_q;
    write_buf_d = write_buf_q;
    addr_err_d  = addr_err_q;
    if (wr_fire && !wr_in_range) addr_err_d = 1'b1;
    case (state_q)
      ST_FILL: begin
        if (wr_last_fire && frame_done_in) state_d = ST_SWAP;
        else if (wr_last_fire)             state_d = ST_WAIT_VID;
        else if (frame_done_in)            state_d = ST_WAIT_WR;
      end
      ST_WAIT_VID: if (frame_done_in) state_d = ST_SWAP;
      ST_WAIT_WR:  if (wr_last_fire)  state_d = ST_SWAP;
      ST_SWAP: begin
        write_buf_d = !write_buf_q;
        // A display frame ending during the swap already counts for the new frame.
        state_d     = frame_done_in ? ST_WAIT_WR : ST_FILL;
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      state_q     <= ST_FILL;
      write_buf_q <= 1'b0;
      addr_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      write_buf_q <= write_buf_d;
      addr_err_q  <= addr_err_d;
    end
  end

  always_comb begin
    h_ext     = 32'(hcount_in);
    v_ext     = 32'(vcount_in);
    rd_active = (h_ext < 32'(ACT_W)) && (v_ext < 32'(ACT_H));
    rd_addr   = '0;
    if (rd_active)
      rd_addr = ADDR_WIDTH'((h_ext >> SCALE_SHIFT) + 32'(SCREEN_WIDTH) * (v_ext >> SCALE_SHIFT));
  end

  // Both banks are read every cycle so each maps onto a plain single-port-read BRAM.
  always_ff @(posedge pixel_clk_in) begin
    if (wr_fire && wr_in_range && !write_buf_q) mem0[wr_addr_in] <= wr_pixel_in;
    mem0_rd_q <= mem0[rd_addr];
  end

  always_ff @(posedge pixel_clk_in) begin
    if (wr_fire && wr_in_range && write_buf_q) mem1[wr_addr_in] <= wr_pixel_in;
    mem1_rd_q <= mem1[rd_addr];
  end

  always_comb begin
    rd_sel1_d = !write_buf_q;
    act1_d    = rd_active;
    pix2_d    = rd_sel1_q ? mem1_rd_q : mem0_rd_q;
    act2_d    = act1_q;
    rgb_d     = act2_q ? rgb565_to_888(pix2_q) : 24'd0;
    valid_d   = act2_q;
  end

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      rd_sel1_q <= 1'b0;
      act1_q    <= 1'b0;
      pix2_q    <= 16'd0;
      act2_q    <= 1'b0;
      rgb_q     <= 24'd0;
      valid_q   <= 1'b0;
    end else begin
      rd_sel1_q <= rd_sel1_d;
      act1_q    <= act1_d;
      pix2_q    <= pix2_d;
      act2_q    <= act2_d;
      rgb_q     <= rgb_d;
      valid_q   <= valid_d;
    end
  end

`ifdef FB_FRAME_STATS_EN
  logic [15:0] shown_q, shown_d;
  logic [15:0] rep_q, rep_d;

  always_comb begin
    shown_d = shown_q;
    rep_d   = rep_q;
    if (frame_done_in) begin
      if (shown_q != 16'hFFFF) shown_d = shown_q + 16'd1;
      if ((state_q == ST_WAIT_WR) && (rep_q != 16'hFFFF)) rep_d = rep_q + 16'd1;
    end
  end

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      shown_q <= 16'd0;
      rep_q   <= 16'd0;
    end else begin
      shown_q <= shown_d;
      rep_q   <= rep_d;
    end
  end

  assign frames_shown_out    = shown_q;
  assign frames_repeated_out = rep_q;
`endif

  assign wr_ready_out  = !wr_done;
  assign swap_out      = (state_q == ST_SWAP);
  assign write_buf_out = write_buf_q;
  assign addr_err_out  = addr_err_q;
  assign rgb_out       = rgb_q;
  assign rgb_valid_out = valid_q;

endmodule

// File: tb/tb_double_frame_buffer.sv
// Bench for double_frame_buffer: directed test-plan steps plus random traffic,
// checked every cycle against a flag/queue level model of the buffer.
module tb_double_frame_buffer;
  localparam int W     = 320;
  localparam int H     = 180;
  localparam int SCALE = 4;
  localparam int DEPTH = W * H;
  localparam int AW    = 16;

  logic          clk = 1'b0;
  logic          rst_in = 1'b1;
  logic [10:0]   hcount_in = 11'd1300;
  logic [9:0]    vcount_in = 10'd0;
  logic          frame_done_in = 1'b0;
  logic          wr_valid_in = 1'b0;
  logic          wr_ready_out;
  logic [AW-1:0] wr_addr_in = '0;
  logic [15:0]   wr_pixel_in = '0;
  logic          wr_last_in = 1'b0;
  logic [23:0]   rgb_out;
  logic          rgb_valid_out;
  logic          swap_out;
  logic          write_buf_out;
  logic          addr_err_out;
`ifdef FB_FRAME_STATS_EN
  logic [15:0]   frames_shown_out;
  logic [15:0]   frames_repeated_out;
`endif

  always #5 clk = ~clk;

  double_frame_buffer dut (
    .pixel_clk_in  (clk),
    .rst_in        (rst_in),
    .hcount_in     (hcount_in),
    .vcount_in     (vcount_in),
    .frame_done_in (frame_done_in),
    .wr_valid_in   (wr_valid_in),
    .wr_ready_out  (wr_ready_out),
    .wr_addr_in    (wr_addr_in),
    .wr_pixel_in   (wr_pixel_in),
    .wr_last_in    (wr_last_in),
    .rgb_out       (rgb_out),
    .rgb_valid_out (rgb_valid_out),
    .swap_out      (swap_out),
    .write_buf_out (write_buf_out),
    .addr_err_out  (addr_err_out)
`ifdef FB_FRAME_STATS_EN
    ,
    .frames_shown_out    (frames_shown_out),
    .frames_repeated_out (frames_repeated_out)
`endif
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] exp888(input logic [15:0] p);
    int r, g, b;
    r = p / 2048;
    g = (p / 32) % 64;
    b = p % 32;
    r = r * 8 + r / 4;
    g = g * 4 + g / 16;
    b = b * 8 + b / 4;
    return 24'(r * 65536 + g * 256 + b);
  endfunction

  // Reference model: flags, two sparse memories and a 3-deep output queue.
  typedef struct {
    bit          v;
    bit          k;
    logic [23:0] rgb;
  } pix_t;

  bit          mdl_live = 0;
  bit          m_wr_done, m_rd_done, m_wb, m_err;
  int          m_shown, m_rep;
  logic [15:0] mm0 [int];
  logic [15:0] mm1 [int];
  pix_t        pq [$];
  pix_t        s_px;
  bit          s_fire, s_act;
  int          s_ra, s_wa;

  always @(negedge clk) begin
    if (mdl_live) begin
      check("write_buf", write_buf_out, m_wb);
      check("wr_ready", wr_ready_out, !m_wr_done);
      check("swap", swap_out, m_wr_done && m_rd_done);
      check("addr_err", addr_err_out, m_err);
      check("rgb_valid", rgb_valid_out, pq[0].v);
      if (!pq[0].v) check("rgb_blank", rgb_out, 0);
      else if (pq[0].k) check("rgb", rgb_out, pq[0].rgb);
`ifdef FB_FRAME_STATS_EN
      check("frames_shown", frames_shown_out, m_shown);
      check("frames_repeated", frames_repeated_out, m_rep);
`endif
    end
    if (rst_in) begin
      mdl_live  = 1;
      m_wr_done = 0;
      m_rd_done = 0;
      m_wb      = 0;
      m_err     = 0;
      m_shown   = 0;
      m_rep     = 0;
      pq.delete();
      s_px = '{v: 0, k: 0, rgb: 24'd0};
      repeat (3) pq.push_back(s_px);
    end else if (mdl_live) begin
      s_act = (int'(hcount_in) < W * SCALE) && (int'(vcount_in) < H * SCALE);
      s_ra  = s_act ? int'(hcount_in) / SCALE + W * (int'(vcount_in) / SCALE) : 0;
      s_px.v = s_act;
      s_px.k = m_wb ? mm0.exists(s_ra) : mm1.exists(s_ra);
      s_px.rgb = 24'd0;
      if (s_px.k) s_px.rgb = exp888(m_wb ? mm0[s_ra] : mm1[s_ra]);
      void'(pq.pop_front());
      pq.push_back(s_px);

      s_fire = wr_valid_in && !m_wr_done;
      s_wa   = int'(wr_addr_in);
      if (s_fire) begin
        if (s_wa < DEPTH) begin
          if (m_wb) mm1[s_wa] = wr_pixel_in;
          else      mm0[s_wa] = wr_pixel_in;
        end else begin
          m_err = 1;
        end
      end

      if (frame_done_in) begin
        if (m_shown < 65535) m_shown++;
        if (m_rd_done && !m_wr_done && m_rep < 65535) m_rep++;
      end

      if (m_wr_done && m_rd_done) begin
        m_wb      = !m_wb;
        m_wr_done = 0;
        m_rd_done = frame_done_in;
      end else begin
        if (s_fire && wr_last_in) m_wr_done = 1;
        if (frame_done_in) m_rd_done = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_px(input int a, input logic [15:0] p, input bit last);
    wr_valid_in = 1'b1;
    wr_addr_in  = AW'(a);
    wr_pixel_in = p;
    wr_last_in  = last;
    tick();
    wr_valid_in = 1'b0;
    wr_last_in  = 1'b0;
  endtask

  task automatic rd_at(input int a);
    hcount_in = 11'((a % W) * SCALE + $urandom_range(0, SCALE - 1));
    vcount_in = 10'((a / W) * SCALE + $urandom_range(0, SCALE - 1));
  endtask

  int          hist [$];
  int          mid_a [8];
  logic [15:0] mid_p [8];
  int          ra;

  initial begin
    repeat (3) tick();
    check("rst_write_buf", write_buf_out, 0);
    check("rst_wr_ready", wr_ready_out, 1);
    check("rst_rgb", rgb_out, 0);
    check("rst_rgb_valid", rgb_valid_out, 0);
    check("rst_swap", swap_out, 0);
    check("rst_addr_err", addr_err_out, 0);
    rst_in = 1'b0;

    // Post-reset fill and handshake
    wr_px(0, 16'hF800, 0);
    wr_px(1, 16'h07E0, 0);
    wr_px(57599, 16'h001F, 1);
    check("hs_ready_low", wr_ready_out, 0);
    wr_valid_in = 1'b1;
    wr_addr_in  = '0;
    wr_pixel_in = 16'h1234;
    repeat (4) tick();
    check("hs_ready_held", wr_ready_out, 0);
    wr_valid_in = 1'b0;
    frame_done_in = 1'b1;
    tick();
    frame_done_in = 1'b0;
    check("swap_pulse", swap_out, 1);
    check("swap_buf_before", write_buf_out, 0);
    tick();
    check("swap_pulse_end", swap_out, 0);
    check("swap_buf_after", write_buf_out, 1);
    check("hs_ready_back", wr_ready_out, 1);

    // Reads and upscale
    hcount_in = 11'd0; vcount_in = 10'd0;
    repeat (3) tick();
    check("rd_first_px", rgb_out, 24'hFF0000);
    check("rd_first_valid", rgb_valid_out, 1);
    hcount_in = 11'd1279; vcount_in = 10'd719;
    repeat (3) tick();
    check("rd_last_px", rgb_out, 24'h0000FF);
    for (int v = 0; v < 4; v++)
      for (int h = 0; h < 4; h++) begin
        hcount_in = 11'(h); vcount_in = 10'(v);
        tick();
      end
    repeat (2) tick();
    check("upscale_corner", rgb_out, 24'hFF0000);
    hcount_in = 11'd4; vcount_in = 10'd0;
    repeat (3) tick();
    check("upscale_next", rgb_out, 24'h00FF00);
    hcount_in = 11'd1280;
    repeat (3) tick();
    check("blank_valid", rgb_valid_out, 0);
    check("blank_rgb", rgb_out, 0);

    // Simultaneous last write and frame_done
    for (int i = 0; i < 6; i++) begin
      ra = $urandom_range(0, DEPTH - 1);
      hist.push_back(ra);
      wr_px(ra, 16'($urandom), 0);
    end
    check("sim_no_swap_yet", swap_out, 0);
    frame_done_in = 1'b1;
    wr_px(42, 16'hBEEF, 1);
    frame_done_in = 1'b0;
    hist.push_back(42);
    check("sim_swap_1cyc", swap_out, 1);
    tick();
    check("sim_buf", write_buf_out, 0);

    // Frame repeat
    rst_in = 1'b1; tick(); rst_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      frame_done_in = 1'b1; tick(); frame_done_in = 1'b0;
      repeat (5) tick();
    end
    check("rep_buf", write_buf_out, 0);
    check("rep_ready", wr_ready_out, 1);
`ifdef FB_FRAME_STATS_EN
    check("rep_shown", frames_shown_out, 3);
    check("rep_repeated", frames_repeated_out, 2);
`endif
    wr_px(7, 16'h5555, 1);
    check("rep_swap", swap_out, 1);
    tick();
    check("rep_buf_after", write_buf_out, 1);

    // Range error
    wr_px(57600, 16'hABCD, 0);
    check("range_err", addr_err_out, 1);
    repeat (10) tick();
    check("range_err_held", addr_err_out, 1);

    // Reset mid-frame while writing buffer 1
    for (int i = 0; i < 8; i++) begin
      mid_a[i] = 100 + i * 977;
      mid_p[i] = 16'($urandom);
      wr_px(mid_a[i], mid_p[i], 0);
    end
    rst_in = 1'b1; tick(); rst_in = 1'b0;
    check("mid_rst_buf", write_buf_out, 0);
    check("mid_rst_ready", wr_ready_out, 1);
    check("mid_rst_valid", rgb_valid_out, 0);
    check("mid_rst_err", addr_err_out, 0);
    for (int i = 0; i < 8; i++) begin
      rd_at(mid_a[i]);
      repeat (3) tick();
      check("mid_rst_keep", rgb_out, exp888(mid_p[i]));
    end

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      rst_in        = ($urandom_range(0, 999) == 0);
      wr_valid_in   = $urandom_range(0, 1) == 1;
      wr_last_in    = $urandom_range(0, 63) == 0;
      frame_done_in = $urandom_range(0, 39) == 0;
      wr_pixel_in   = 16'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        wr_addr_in = AW'($urandom_range(DEPTH, 65535));
      end else begin
        ra = $urandom_range(0, DEPTH - 1);
        wr_addr_in = AW'(ra);
        if (hist.size() < 2000) hist.push_back(ra);
      end
      if ($urandom_range(0, 1) == 1 && hist.size() > 0) begin
        rd_at(hist[$urandom_range(0, hist.size() - 1)]);
      end else begin
        hcount_in = 11'($urandom_range(0, 1400));
        vcount_in = 10'($urandom_range(0, 760));
      end
      tick();
    end
    rst_in = 1'b0;
    wr_valid_in = 1'b0;
    frame_done_in = 1'b0;
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
